// File: rtl/sha256_digest_serializer.sv
// ============================================================================
// Module   : sha256_digest_serializer
// Purpose  : Buffers 256-bit SHA256 digests and streams each one as eight
//            32-bit words (MSW first) over valid/ready; flags dropped digests.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sha256_digest_serializer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dout_vld,
    input  logic [255:0]     dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             m_last,
    output logic [2:0]       m_word_idx,
    output logic             busy,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] digest_cnt
);

    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0]    c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [CNT_BITS-1:0] c_depth    = CNT_BITS'(DEPTH);

    logic [255:0]          r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_BITS-1:0]   r_count;
    logic [2:0]            r_word_idx;
    logic                  r_ovf;
    logic [CNT_W-1:0]      r_digest_cnt;

    logic                  w_valid;
    logic                  w_xfer;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_drop;
    logic [255:0]          w_entry;
    logic [255:0]          w_shifted;

    assign w_valid = (r_count != '0);
    assign w_xfer  = w_valid & m_ready;
    assign w_pop   = w_xfer & (r_word_idx == 3'd7);
    assign w_full  = (r_count == c_depth);
    // A pop on the same edge frees the head slot, so a full buffer can still accept.
    assign w_wr    = dout_vld & (~w_full | w_pop);
    assign w_drop  = dout_vld & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_word_idx   <= '0;
            r_ovf        <= 1'b0;
            r_digest_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_xfer) begin
                r_word_idx <= r_word_idx + 3'd1;
            end
            if (w_pop) begin
                r_rd_ptr     <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + PTR_W'(1);
                r_digest_cnt <= r_digest_cnt + CNT_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_BITS'(1);
                2'b01:   r_count <= r_count - CNT_BITS'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Word 0 lives in bits [255:224]; shift the selected word to the top.
    assign w_entry    = r_mem[r_rd_ptr];
    assign w_shifted  = w_entry << {r_word_idx, 5'b0};
    assign m_data     = w_shifted[255:224];
    assign m_valid    = w_valid;
    assign busy       = w_valid;
    assign m_last     = w_valid & (r_word_idx == 3'd7);
    assign m_word_idx = r_word_idx;
    assign ovf        = r_ovf;
    assign digest_cnt = r_digest_cnt;

endmodule

`default_nettype wire

// File: doc/sha256_digest_serializer.md
Name: sha256_digest_serializer

Overview:
- Downstream consumer of the SHA256 core output (dout_vld / dout[255:0]).
- Captures each 256-bit digest into a small circular buffer.
- Streams each digest out as eight 32-bit words over a valid/ready interface, most-significant word first.
- Isolates the core, which has no backpressure, from a possibly stalled sink; flags dropped digests.

Parameters:
- DEPTH, 2, number of 256-bit digest entries buffered; legal range 1..16.
- CNT_W, 16, width of the completed-digest counter.

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- dout_vld  input  1  one-cycle pulse from SHA256 core: dout is a valid digest
- dout  input  256  digest; bits [255:224] are word 0
- m_valid  output  1  output word valid
- m_ready  input  1  sink accepts word
- m_data  output  32  current output word
- m_last  output  1  high with word 7 of a digest
- m_word_idx  output  3  index (0..7) of the current word
- busy  output  1  buffer non-empty
- ovf  output  1  sticky: a digest was dropped because the buffer was full
- ovf_clr  input  1  clears ovf
- digest_cnt  output  CNT_W  digests fully transmitted; wraps modulo 2^CNT_W

Behaviour:
- Reset: rst=1 at a clock edge clears all state.
  - wr_ptr, rd_ptr, count, word_idx, ovf and digest_cnt go to 0.
  - m_valid=0, m_last=0, m_word_idx=0, busy=0.
  - m_data is don't-care while m_valid=0.
  - Buffer RAM contents are not reset.
- Reset mid-digest: the partially sent digest and all buffered digests are discarded; no m_last is issued.
- Write:
  - dout_vld=1 and (count<DEPTH, or a pop occurs in the same cycle): store dout at wr_ptr; wr_ptr = (wr_ptr+1) mod DEPTH.
  - dout_vld=1, count==DEPTH and no same-cycle pop: digest dropped; ovf<=1.
- Pop:
  - A transfer is m_valid & m_ready.
  - Transfer with word_idx<7: word_idx increments.
  - Transfer with word_idx==7: word_idx<=0; rd_ptr = (rd_ptr+1) mod DEPTH; digest_cnt increments.
- count:
  - +1 on write only; −1 on pop only.
  - Unchanged on simultaneous write+pop, or on a dropped write.
- Outputs (combinational from registered state):
  - m_valid = busy = (count!=0).
  - m_data = entry[rd_ptr][255−32*word_idx −: 32].
  - m_last = m_valid & (word_idx==7).
  - m_word_idx = word_idx.
- Latency: dout_vld at edge N, buffer empty → m_valid=1 with word 0 after edge N.
  - Best case: 8 cycles per digest with m_ready held 1.
  - Back-to-back digests stream with no idle cycle between word 7 and the next word 0.
- Handshake rules:
  - Once m_valid=1, m_data, m_last and m_word_idx stay stable until the transfer.
  - m_valid never drops without a transfer, except on rst.
  - m_valid does not depend combinationally on m_ready.
- Write into the entry being read: impossible, because the full check uses count.
  - With DEPTH=1, a write concurrent with the final pop overwrites the head only after word 7 is taken (same edge).
- ovf:
  - Set has priority over ovf_clr in the same cycle.
  - ovf_clr alone clears it next edge.
  - Dropping a digest does not disturb the digest being transmitted.
- digest_cnt: 2^CNT_W−1 → 0 on the next completed digest; no flag.

Test Plan:
- Single digest, DEPTH=2, m_ready=1:
  - Stimulus: dout=256'h00010203_04050607_..._1C1D1E1F.
  - Response: m_data 00010203, 04050607, …, 1C1D1E1F over 8 consecutive cycles, starting the cycle after dout_vld.
  - m_last only on 1C1D1E1F; digest_cnt=1; busy=0 afterwards.
- Backpressure:
  - Stimulus: m_ready toggles 1,0,0,1,… during one digest.
  - Response: m_data/m_word_idx hold during stalls; all 8 words are delivered in order, each exactly once.
- Overflow, DEPTH=2, m_ready=0:
  - Stimulus: three dout_vld pulses carrying digests A, B, C.
  - Response: ovf=1 after the third; with m_ready=1, A then B stream out (16 words); C never appears; digest_cnt=2.
- Full with simultaneous pop, DEPTH=2:
  - Stimulus: buffer holds A, B; dout_vld with C on the same cycle A's word 7 transfers.
  - Response: C accepted; output is B then C; ovf stays 0.
- ovf priority: ovf_clr=1 in the same cycle as a dropped digest leaves ovf=1; ovf_clr on the next cycle clears it to 0.
- Reset mid-stream:
  - Stimulus: rst=1 after word 3 of a digest, with a second digest buffered.
  - Response: next cycle m_valid=0, busy=0, digest_cnt=0, ovf=0.
  - A new digest afterwards starts at word 0.
